// File: rtl/perm_addr_pkg.sv
// Shared types and helpers for the permuted address generator:
// FSM state encoding and the legal-configuration check.
package perm_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A block cannot exceed the address space and rows cannot exceed the block.
    function automatic logic cfg_legal(input int unsigned blk_log,
                                       input int unsigned rows_log,
                                       input int unsigned addr_w);
        return (rows_log <= blk_log) && (blk_log <= addr_w);
    endfunction

endpackage

// File: rtl/perm_rot.sv
// Combinational block permutation: left-rotates the low blk_log bits of the
// index by (blk_log - rows_log); bits above the block pass straight through.
module perm_rot #(
    parameter int ADDR_W = 5,
    parameter int LOG_W  = $clog2(ADDR_W + 1)
) (
    input  logic [ADDR_W-1:0] i_i,
    input  logic [LOG_W-1:0]  blk_log_i,
    input  logic [LOG_W-1:0]  rows_log_i,
    output logic [ADDR_W-1:0] addr_o
);

    int blk;
    int rows;
    int sh;
    int dst;

    // Bit j of the index lands at bit (j + sh) mod blk; constant-index
    // inner loop keeps this a plain mux tree with no multipliers.
    always_comb begin
        blk    = int'(blk_log_i);
        rows   = int'(rows_log_i);
        sh     = blk - rows;
        dst    = 0;
        addr_o = i_i;
        for (int j = 0; j < ADDR_W; j++) begin
            dst = j + sh;
            if (dst >= blk) begin
                dst = dst - blk;
            end
            if (j < blk) begin
                for (int d = 0; d < ADDR_W; d++) begin
                    if (d == dst) begin
                        addr_o[d] = i_i[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/perm_addr_gen.sv
// Block-permuted address sequence generator (0..2^ADDR_W-1 reordered).
// Optional macro PERM_ADDR_GEN_INV_EN adds an inv input selecting the inverse permutation.
module perm_addr_gen
    import perm_addr_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LOG_W  = $clog2(ADDR_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LOG_W-1:0]  blk_log,
    input  logic [LOG_W-1:0]  rows_log,
`ifdef PERM_ADDR_GEN_INV_EN
    input  logic              inv,
`endif
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output state_t            dbg_state
);

    // Handshake: an address transfers on every rising edge where addr_valid
    // and addr_ready are both high; while addr_ready is low, addr_out and
    // addr_valid hold; addr_valid never drops before its transfer.

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LOG_W-1:0]  blk_q, blk_d;
    logic [LOG_W-1:0]  rows_q, rows_d;
    logic              cfg_err_q, cfg_err_d;
    logic [ADDR_W-1:0] i_inc;
    logic [ADDR_W-1:0] rot_addr;
    logic [LOG_W-1:0]  rows_eff;

    // The inverse swaps rows and columns, i.e. rotates by rows_log instead.
`ifdef PERM_ADDR_GEN_INV_EN
    assign rows_eff = inv ? (blk_log - rows_log) : rows_log;
`else
    assign rows_eff = rows_log;
`endif

    assign i_inc = i_q + ADDR_W'(1);

    perm_rot #(
        .ADDR_W (ADDR_W),
        .LOG_W  (LOG_W)
    ) u_rot (
        .i_i        (i_inc),
        .blk_log_i  (blk_q),
        .rows_log_i (rows_q),
        .addr_o     (rot_addr)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        addr_d    = addr_q;
        blk_d     = blk_q;
        rows_d    = rows_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    i_d       = '0;
                    addr_d    = '0;
                    blk_d     = blk_log;
                    rows_d    = rows_eff;
                    cfg_err_d = !cfg_legal(32'(blk_log), 32'(rows_log), ADDR_W);
                end
            end
            ST_RUN: begin
                if (addr_ready) begin
                    if (i_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d    = i_inc;
                        addr_d = cfg_err_q ? i_inc : rot_addr;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            addr_q    <= '0;
            blk_q     <= '0;
            rows_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            blk_q     <= blk_d;
            rows_q    <= rows_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign cfg_err    = cfg_err_q;
    assign dbg_state  = state_q;

endmodule
